// File: rtl/mastermind_scorer.sv
// Mastermind guess scorer: latches a 4-symbol code and guess, scores them over 6 cycles, tracks attempts/win/lose.
// Optional: define SCORER_CODE_REVEAL_EN to drive reveal3..0 with the latched code while lose is set.
module mastermind_scorer #(
  parameter int unsigned MAX_GUESSES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic [1:0] code3,
  input  logic [1:0] code2,
  input  logic [1:0] code1,
  input  logic [1:0] code0,
  input  logic [1:0] guess3,
  input  logic [1:0] guess2,
  input  logic [1:0] guess1,
  input  logic [1:0] guess0,
  input  logic       guess_valid,
  output logic       guess_ready,
  output logic [2:0] exact,
  output logic [2:0] partial,
  output logic       score_valid,
  output logic [3:0] attempts,
  output logic       win,
  output logic       lose,
  output logic [1:0] reveal3,
  output logic [1:0] reveal2,
  output logic [1:0] reveal1,
  output logic [1:0] reveal0
);

  localparam logic [3:0] LP_MAX = 4'(MAX_GUESSES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXACT,
    S_COLOR,
    S_REPORT,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0][1:0] r_code;
  logic [3:0][1:0] r_guess;
  logic [2:0]      r_exact_acc;
  logic [2:0]      r_total_acc;
  logic [1:0]      r_color_idx;
  logic [2:0]      r_exact;
  logic [2:0]      r_partial;
  logic            r_score_valid;
  logic [3:0]      r_attempts;
  logic            r_win;
  logic            r_lose;

  logic [3:0]      w_exact_bits;
  logic [2:0]      w_exact_pop;
  logic [2:0]      w_code_cnt;
  logic [2:0]      w_guess_cnt;
  logic [2:0]      w_min_cnt;
  logic [3:0]      w_attempts_inc;

  always_comb begin
    w_code_cnt  = 3'd0;
    w_guess_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      w_exact_bits[i] = (r_code[i] == r_guess[i]);
      w_code_cnt      = w_code_cnt  + 3'(r_code[i]  == r_color_idx);
      w_guess_cnt     = w_guess_cnt + 3'(r_guess[i] == r_color_idx);
    end
  end

  assign w_exact_pop    = 3'(w_exact_bits[0]) + 3'(w_exact_bits[1])
                        + 3'(w_exact_bits[2]) + 3'(w_exact_bits[3]);
  assign w_min_cnt      = (w_code_cnt < w_guess_cnt) ? w_code_cnt : w_guess_cnt;
  assign w_attempts_inc = (r_attempts == 4'd15) ? 4'd15 : r_attempts + 4'd1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (guess_valid) w_next = S_EXACT;
      S_EXACT:  w_next = S_COLOR;
      S_COLOR:  if (r_color_idx == 2'd3) w_next = S_REPORT;
      S_REPORT: begin
        if (r_exact_acc == 3'd4 || w_attempts_inc == LP_MAX) w_next = S_DONE;
        else                                                 w_next = S_IDLE;
      end
      S_DONE:   w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
    if (new_game) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_code        <= '0;
      r_guess       <= '0;
      r_exact_acc   <= 3'd0;
      r_total_acc   <= 3'd0;
      r_color_idx   <= 2'd0;
      r_exact       <= 3'd0;
      r_partial     <= 3'd0;
      r_score_valid <= 1'b0;
      r_attempts    <= 4'd0;
      r_win         <= 1'b0;
      r_lose        <= 1'b0;
    end else begin
      r_score_valid <= 1'b0;
      if (new_game) begin
        r_exact     <= 3'd0;
        r_partial   <= 3'd0;
        r_attempts  <= 4'd0;
        r_win       <= 1'b0;
        r_lose      <= 1'b0;
        r_color_idx <= 2'd0;
        r_total_acc <= 3'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (guess_valid) begin
              r_code  <= {code3, code2, code1, code0};
              r_guess <= {guess3, guess2, guess1, guess0};
            end
          end
          S_EXACT: begin
            r_exact_acc <= w_exact_pop;
            r_color_idx <= 2'd0;
            r_total_acc <= 3'd0;
          end
          S_COLOR: begin
            r_total_acc <= r_total_acc + w_min_cnt;
            r_color_idx <= r_color_idx + 2'd1;
          end
          S_REPORT: begin
            // Exact matches are a subset of colour matches, so the subtraction cannot wrap.
            r_exact       <= r_exact_acc;
            r_partial     <= r_total_acc - r_exact_acc;
            r_score_valid <= 1'b1;
            r_attempts    <= w_attempts_inc;
            if (r_exact_acc == 3'd4)              r_win  <= 1'b1;
            else if (w_attempts_inc == LP_MAX)    r_lose <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign guess_ready = (r_state == S_IDLE) && !reset;
  assign exact       = r_exact;
  assign partial     = r_partial;
  assign score_valid = r_score_valid;
  assign attempts    = r_attempts;
  assign win         = r_win;
  assign lose        = r_lose;

`ifdef SCORER_CODE_REVEAL_EN
  assign {reveal3, reveal2, reveal1, reveal0} = r_lose ? r_code : 8'd0;
`else
  assign {reveal3, reveal2, reveal1, reveal0} = 8'd0;
`endif

endmodule

// File: tb/tb_mastermind_scorer.sv
// Scoreboard bench for mastermind_scorer: random and directed guesses scored by a pairing-based reference model.
module tb_mastermind_scorer;

  localparam int unsigned TB_MAX = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       new_game;
  logic [7:0] drv_code;
  logic [7:0] drv_guess;
  logic       guess_valid;
  logic       guess_ready;
  logic [2:0] exact;
  logic [2:0] partial;
  logic       score_valid;
  logic [3:0] attempts;
  logic       win;
  logic       lose;
  logic [1:0] reveal3, reveal2, reveal1, reveal0;

  mastermind_scorer #(.MAX_GUESSES(TB_MAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .new_game   (new_game),
    .code3      (drv_code[7:6]),
    .code2      (drv_code[5:4]),
    .code1      (drv_code[3:2]),
    .code0      (drv_code[1:0]),
    .guess3     (drv_guess[7:6]),
    .guess2     (drv_guess[5:4]),
    .guess1     (drv_guess[3:2]),
    .guess0     (drv_guess[1:0]),
    .guess_valid(guess_valid),
    .guess_ready(guess_ready),
    .exact      (exact),
    .partial    (partial),
    .score_valid(score_valid),
    .attempts   (attempts),
    .win        (win),
    .lose       (lose),
    .reveal3    (reveal3),
    .reveal2    (reveal2),
    .reveal1    (reveal1),
    .reveal0    (reveal0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] e;
    logic [2:0] p;
    logic [3:0] att;
    logic       w;
    logic       l;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;

  int n_checks = 0;
  int n_pass   = 0;

  // Game model state
  int         m_attempts = 0;
  logic       m_win  = 1'b0;
  logic       m_lose = 1'b0;
  logic [7:0] m_code = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  // Classic scoring: pair exact hits first, then pair each leftover guess peg with an unused code peg.
  function automatic void score_ref(input logic [7:0] c, input logic [7:0] g,
                                    output int e, output int p);
    bit cu[4];
    bit gu[4];
    bit found;
    e = 0;
    p = 0;
    for (int i = 0; i < 4; i++) begin
      cu[i] = 1'b0;
      gu[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++)
      if (c[2*i +: 2] == g[2*i +: 2]) begin
        e++;
        cu[i] = 1'b1;
        gu[i] = 1'b1;
      end
    for (int i = 0; i < 4; i++) begin
      found = 1'b0;
      if (!gu[i])
        for (int j = 0; j < 4; j++)
          if (!found && !cu[j] && c[2*j +: 2] == g[2*i +: 2]) begin
            cu[j] = 1'b1;
            found = 1'b1;
            p++;
          end
    end
  endfunction

  function automatic logic [7:0] exp_reveal();
`ifdef SCORER_CODE_REVEAL_EN
    return m_lose ? m_code : 8'd0;
`else
    return 8'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_attempts"}, attempts, m_attempts);
    check({tag, "_win"}, win, m_win);
    check({tag, "_lose"}, lose, m_lose);
    check({tag, "_reveal"}, {reveal3, reveal2, reveal1, reveal0}, exp_reveal());
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    m_attempts = 0;
    m_win  = 1'b0;
    m_lose = 1'b0;
    check("ng_exact", exact, 0);
    check("ng_partial", partial, 0);
    check("ng_ready", guess_ready, 1);
    check_status("ng");
  endtask

  task automatic wait_ready();
    int waited = 0;
    while (!guess_ready && waited < 20) begin
      step();
      waited++;
    end
    check("ready_before_guess", guess_ready, 1);
  endtask

  // Present a guess, push the expected score, scramble the inputs at T+2, return at T+6.
  task automatic play(input logic [7:0] c, input logic [7:0] g);
    int   e, p;
    exp_t x;
    wait_ready();
    drv_code    = c;
    drv_guess   = g;
    guess_valid = 1'b1;
    step();
    guess_valid = 1'b0;
    score_ref(c, g, e, p);
    m_code = c;
    if (m_attempts < 15) m_attempts++;
    if (e == 4) m_win = 1'b1;
    else if (m_attempts == int'(TB_MAX)) m_lose = 1'b1;
    x.cyc = cyc;
    x.e   = 3'(e);
    x.p   = 3'(p);
    x.att = 4'(m_attempts);
    x.w   = m_win;
    x.l   = m_lose;
    sb.push_back(x);
    step();
    step();
    drv_code  = 8'($urandom);
    drv_guess = 8'($urandom);
    repeat (4) step();
    check("ready_after_report", guess_ready, !(m_win || m_lose));
  endtask

  always @(negedge clk) begin
    if (!reset && score_valid) begin
      if (sb.size() == 0) begin
        check("spurious_score_valid", score_valid, 0);
      end else begin
        mon_x = sb.pop_front();
        check("latency", cyc, mon_x.cyc + 6);
        check("exact", exact, mon_x.e);
        check("partial", partial, mon_x.p);
        check("attempts", attempts, mon_x.att);
        check("win", win, mon_x.w);
        check("lose", lose, mon_x.l);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] c, g;
    reset       = 1'b1;
    new_game    = 1'b0;
    drv_code    = 8'd0;
    drv_guess   = 8'd0;
    guess_valid = 1'b0;
    #3;
    check("rst_ready", guess_ready, 0);
    check("rst_valid", score_valid, 0);
    check("rst_exact", exact, 0);
    check("rst_partial", partial, 0);
    check_status("rst");
    step();
    step();
    reset = 1'b0;
    #1;
    check("post_rst_ready", guess_ready, 1);

    // Full permutation: all colours, no exact hits.
    play(8'b11_10_01_00, 8'b00_01_10_11);
    // Duplicate colours.
    play(8'b01_01_10_11, 8'b01_10_01_01);

    // Win on the first guess, then ignored guesses in DONE.
    do_new_game();
    play(8'b11_10_01_00, 8'b11_10_01_00);
    guess_valid = 1'b1;
    repeat (8) step();
    guess_valid = 1'b0;
    check("done_ready", guess_ready, 0);
    check_status("done");

    // Lose after TB_MAX misses.
    do_new_game();
    for (int i = 0; i < int'(TB_MAX); i++) play(8'h00, 8'h55);
    check_status("lost");
    do_new_game();

    // Reset in the middle of scoring.
    play(8'b11_10_01_00, 8'b11_10_00_01);
    wait_ready();
    drv_code    = 8'b00_01_10_11;
    drv_guess   = 8'b00_01_10_11;
    guess_valid = 1'b1;
    step();
    guess_valid = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    #1;
    m_attempts = 0;
    m_win  = 1'b0;
    m_lose = 1'b0;
    check("midrst_ready", guess_ready, 0);
    check("midrst_exact", exact, 0);
    check("midrst_partial", partial, 0);
    check_status("midrst");
    step();
    reset = 1'b0;
    #1;
    check("midrst_release_ready", guess_ready, 1);
    play(8'b10_10_01_11, 8'b10_01_10_00);

    // new_game aborts a guess in flight.
    wait_ready();
    drv_code    = 8'b11_11_11_11;
    drv_guess   = 8'b11_11_11_11;
    guess_valid = 1'b1;
    step();
    guess_valid = 1'b0;
    repeat (3) step();
    do_new_game();
    repeat (6) step();
    check("abort_ready", guess_ready, 1);
    check_status("abort");

    // Random games.
    for (int n = 0; n < 60; n++) begin
      if (m_win || m_lose) do_new_game();
      c = 8'($urandom);
      g = ($urandom_range(0, 3) == 0) ? c : 8'($urandom);
      play(c, g);
    end

    repeat (4) step();
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mastermind_scorer.md
Name: mastermind_scorer

Overview:
- Consumer side of the secret-code interface. Takes the four 2-bit code symbols from the code generator and a player guess, then scores the guess with a multi-cycle FSM.
- Score output: exact count (right colour, right position) and partial count (right colour, wrong position).
- Tracks the attempt count and flags win/lose. Feeds the display/game-control logic.

Parameters:
- MAX_GUESSES, 10, guesses allowed per game before lose; legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- new_game  input  1  synchronous restart: clears attempts/win/lose, returns to IDLE
- code3, code2, code1, code0  input  2 each  secret code symbols (colour 0..3)
- guess3, guess2, guess1, guess0  input  2 each  player guess symbols
- guess_valid  input  1  guess presented
- guess_ready  output  1  scorer can accept a guess
- exact  output  3  right colour/right position count, 0..4
- partial  output  3  right colour/wrong position count, 0..4
- score_valid  output  1  one-cycle pulse; exact/partial valid
- attempts  output  4  guesses scored this game
- win  output  1  game won (sticky)
- lose  output  1  game lost (sticky)
- reveal3, reveal2, reveal1, reveal0  output  2 each  code reveal (see Optional Feature)

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0; guess_ready=0 while reset asserted, 1 in IDLE after release.
- States: IDLE, EXACT, COLOR, REPORT, DONE.
- IDLE:
  - guess_ready=1.
  - On a clock edge with guess_valid&guess_ready (accept edge T), latch code3..0 and guess3..0 into internal registers → EXACT.
  - Code or guess changes after T are ignored.
- EXACT (1 cycle):
  - Per position i, set exact bit if latched code_i==guess_i.
  - exact_acc = popcount of the exact bits.
  - color_idx=0, total_acc=0.
- COLOR (4 cycles, color_idx 0..3):
  - total_acc += min(count of color_idx in code, count of color_idx in guess).
  - After color_idx=3 → REPORT.
- REPORT (1 cycle):
  - exact=exact_acc; partial=total_acc−exact_acc (never negative); score_valid=1; attempts+=1.
  - If exact_acc==4: win=1 → DONE.
  - Else if new attempts==MAX_GUESSES: lose=1 → DONE.
  - Else → IDLE.
- Latency: score_valid high in the cycle starting at edge T+6, for exactly one cycle. Throughput is one guess per 7 cycles max.
- exact/partial hold their last value until the next REPORT; cleared by reset or new_game.
- guess_ready=0 in EXACT, COLOR, REPORT, DONE.
- DONE: stays until new_game or reset; guesses ignored.
- new_game:
  - Takes priority over everything except reset, in any state, including mid-scoring.
  - Next state IDLE; attempts, win, lose, exact, partial = 0.
  - No score_valid for an aborted guess.
- Reset mid-scoring: immediate return to IDLE values; no score_valid pulse.
- Arithmetic: per-colour counts 3 bits; total_acc 3 bits (max 4); attempts saturates at 15 (unreachable with legal MAX_GUESSES).

Optional Feature:
- Macro SCORER_CODE_REVEAL_EN.
- Defined: reveal3..0 = latched code while lose=1, else 0.
- Undefined: reveal3..0 tied to 0; no extra logic.
- All other behaviour identical.

Test Plan:
- code=3,2,1,0 (code3..code0), guess=3,2,1,0 accepted at T → at T+6 score_valid=1, exact=4, partial=0, attempts=1, win=1; guess_ready stays 0; a further guess_valid is ignored.
- code=3,2,1,0, guess=0,1,2,3 → exact=0, partial=4, win=0; guess_ready=1 the cycle after REPORT.
- code=1,1,2,3, guess=1,2,1,1 → exact=1, partial=2.
- MAX_GUESSES=10, code=0,0,0,0, ten guesses of 1,1,1,1 → each exact=0, partial=0; after 10th, attempts=10, lose=1; with SCORER_CODE_REVEAL_EN, reveal=0,0,0,0 matches code; new_game → attempts=0, lose=0, guess_ready=1.
- Accept guess, assert reset during COLOR → outputs 0 immediately, no score_valid; after release, guess_ready=1 and next guess scores correctly with attempts=1.
- Change code inputs at T+2 during scoring → score uses code latched at T; new_game at T+3 → no score_valid, state IDLE.
